// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared vector-core types and vmem model defaults
package core_pkg;

  localparam int unsigned VrfDataWidth = 64;
  typedef logic [VrfDataWidth-1:0] vrf_data_t;

  typedef logic [31:0] vmem_cnt_t;

  localparam int unsigned VmemDepthDefault       = 16;
  localparam int unsigned VmemLoadLatencyDefault = 2;

endpackage

// File: rtl/gnt_throttle.sv
// rtl/gnt_throttle.sv - periodic store-grant throttle; blocks one grant every StallPeriod valid cycles
module gnt_throttle #(
  parameter int unsigned StallPeriod = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic gnt_o
);

  localparam int unsigned CntW = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;
  localparam logic [CntW-1:0] CntLast = (StallPeriod > 0) ? CntW'(StallPeriod - 1) : '0;

  logic [CntW-1:0] stall_cnt;
  logic            stall_hit;

  // StallPeriod = 1 hits every cycle, so no grant is ever issued.
  assign stall_hit = (StallPeriod != 0) && (stall_cnt == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (valid_i && (StallPeriod != 0)) begin
      stall_cnt <= stall_hit ? '0 : stall_cnt + 1'b1;
    end
  end

  assign gnt_o = valid_i & rst_ni & ~stall_hit;

endmodule

// File: rtl/vmem_stream_model.sv
// rtl/vmem_stream_model.sv - preloaded memory model streaming load operands and absorbing store operands
module vmem_stream_model
  import core_pkg::*;
#(
  parameter int unsigned DataWidth      = $bits(vrf_data_t),
  parameter int unsigned Depth          = VmemDepthDefault,
  parameter int unsigned LoadLatency    = VmemLoadLatencyDefault,
  parameter int unsigned StallPeriod    = 0,
  parameter int unsigned ExpectedStores = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 load_op_valid_o,
  input  logic                 load_op_ready_i,
  output logic [DataWidth-1:0] load_op_o,
  input  logic                 store_op_valid_i,
  input  logic [DataWidth-1:0] store_op_i,
  output logic                 store_op_gnt_o,
  output vmem_cnt_t            load_cnt_o,
  output vmem_cnt_t            store_cnt_o,
  output logic                 done_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LatW = (LoadLatency > 0) ? $clog2(LoadLatency + 1) : 1;
  localparam logic [LatW-1:0] LatMax = LatW'(LoadLatency);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      rd_ptr, wr_ptr;
  logic [LatW-1:0]      lat_cnt;
  logic                 load_hs;
  vmem_cnt_t            store_cnt_nxt;

  assign load_op_valid_o = (lat_cnt == LatMax);
  assign load_hs         = load_op_valid_o & load_op_ready_i;
  assign load_op_o       = mem[rd_ptr];
  assign store_cnt_nxt   = store_cnt_o + 1'b1;

  gnt_throttle #(
    .StallPeriod(StallPeriod)
  ) u_gnt_throttle (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(store_op_valid_i),
    .gnt_o  (store_op_gnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt    <= '0;
      rd_ptr     <= '0;
      load_cnt_o <= '0;
    end else if (load_hs) begin
      lat_cnt    <= '0;
      rd_ptr     <= rd_ptr + 1'b1;
      load_cnt_o <= load_cnt_o + 1'b1;
    end else if (lat_cnt != LatMax) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  // Reads are combinational off mem, so a same-cycle store to rd_ptr is seen only next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem[i] <= DataWidth'(i);
      wr_ptr      <= '0;
      store_cnt_o <= '0;
      done_o      <= 1'b0;
    end else if (store_op_gnt_o) begin
      mem[wr_ptr] <= store_op_i;
      wr_ptr      <= wr_ptr + 1'b1;
      store_cnt_o <= store_cnt_nxt;
      if (store_cnt_nxt == vmem_cnt_t'(ExpectedStores)) done_o <= 1'b1;
    end
  end

endmodule

// File: doc/vmem_stream_model.md
VMEM_STREAM_MODEL -- requirements
Module: vmem_stream_model

Interface
REQ-001 Parameter DataWidth, default 64, width of one load/store operand; equals the width of core_pkg::vrf_data_t.
REQ-002 Parameter Depth, default 16, number of memory entries; power of two, minimum 2.
REQ-003 Parameter LoadLatency, default 2, number of idle cycles between load handshakes; 0 means back-to-back.
REQ-004 Parameter StallPeriod, default 0, store-grant throttle period; 0 means never throttle.
REQ-005 Parameter ExpectedStores, default 8, store count that raises done_o.
REQ-006 clk_i  in  1  single clock; everything samples on posedge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 load_op_valid_o  out  1  load operand available.
REQ-009 load_op_ready_i  in  1  consumer accepts the load operand.
REQ-010 load_op_o  out  DataWidth  load operand, mem[rd_ptr].
REQ-011 store_op_valid_i  in  1  producer offers a store operand.
REQ-012 store_op_i  in  DataWidth  store operand.
REQ-013 store_op_gnt_o  out  1  store operand accepted this cycle.
REQ-014 load_cnt_o  out  32  completed load handshakes.
REQ-015 store_cnt_o  out  32  completed store grants.
REQ-016 done_o  out  1  sticky flag; set once store_cnt reaches ExpectedStores.

Function
REQ-017 Load handshake: valid & ready on a posedge.
- rd_ptr increments modulo Depth.
- load_cnt increments, wrapping at 2^32.
REQ-018 Load valid/data stability:
- Once asserted, load_op_valid_o stays high until the handshake completes.
- load_op_o stays stable while valid is high, except when a same-cycle store to rd_ptr changes it (REQ-025).
REQ-019 Load latency counter (width clog2(LoadLatency+1)):
- Cleared by reset and by every load handshake.
- Increments each cycle while below LoadLatency.
- load_op_valid_o = (counter == LoadLatency).
- Result: after a handshake, valid is low for exactly LoadLatency cycles.
REQ-020 load_op_o is a combinational read of mem[rd_ptr] with no output register.
REQ-021 store_op_gnt_o is asserted only when store_op_valid_i is high and the throttle (REQ-022) does not block; it never precedes valid.
REQ-022 Throttle (StallPeriod = P > 0):
- stall_cnt increments in each cycle store_op_valid_i is high.
- When stall_cnt == P-1: gnt is forced low that cycle and stall_cnt returns to 0.
- P = 0: gnt = store_op_valid_i.
- P = 1: gnt is never asserted. This is legal and documented as a deadlock mode.
REQ-023 Store grant:
- mem[wr_ptr] <= store_op_i.
- wr_ptr increments modulo Depth.
- store_cnt increments, wrapping at 2^32.
REQ-024 done_o is registered.
- Set on the posedge where store_cnt becomes ExpectedStores.
- Stays high until reset, including after store_cnt wraps.
REQ-025 Store to the entry at rd_ptr in the same cycle as a load handshake: the load returns the old value; the new value is visible from the next cycle.
REQ-026 Pointer wrap: Depth-1 -> 0 with no full/empty tracking; the model is a memory, not a FIFO.
REQ-027 Load and store sides are independent; any combination of simultaneous handshakes is legal.

Reset
REQ-028 While rst_ni is low, asynchronously:
- Outputs: load_op_valid_o = 0 (when LoadLatency > 0), store_op_gnt_o = 0, load_cnt_o = 0, store_cnt_o = 0, done_o = 0.
- Internal state: rd_ptr = 0, wr_ptr = 0, stall_cnt = 0, latency counter = 0.
- Memory: mem[i] = i, zero-extended, for every i.
REQ-029 When LoadLatency = 0, load_op_valid_o is high in the first cycle after reset release. When LoadLatency > 0, it rises LoadLatency cycles after release.
REQ-030 Reset asserted mid-transfer discards any in-progress handshake and restores REQ-028 state; no partial write occurs.

Structure
REQ-031 vrf_data_t comes from core_pkg.
REQ-032 A vmem_model_pkg-level typedef vmem_cnt_t (32 bits) and default constants for Depth and LoadLatency belong in core_pkg.
REQ-033 One sub-module, gnt_throttle, owns stall_cnt and the REQ-022 gating. Its ports are clk_i, rst_ni, valid_i and gnt_o.

Verification
REQ-034 Defaults, ready held at 1: valid rises at cycle 2 after reset, then every 3rd cycle. Data sequence is 0,1,2,...,15,0.
REQ-035 LoadLatency = 0, ready toggling 1,0,1: valid is held high and data is stable across the ready=0 cycle; load_cnt = 2 after 3 cycles.
REQ-036 StallPeriod = 3, store_op_valid_i held high with data 0xA0+n: gnt pattern is 1,1,0 repeating. mem[0..3] = A0,A1,A2,A3 and store_cnt = 4 after 6 cycles.
REQ-037 ExpectedStores = 8: done_o rises on the posedge of the 8th grant, and stays high after 20 more grants.
REQ-038 Store to entry 0 in the same cycle as load handshake 0: the load returns 0; after rd_ptr wraps, the load at entry 0 returns the stored value.
REQ-039 Assert rst_ni low for 1 cycle in the middle of a stream: all counters read 0, and the next load data is 0 with the preload restored.
